// File: rtl/octave_sched_pkg.sv
// rtl/octave_sched_pkg.sv - shared types and constants for octave_param_scheduler
// Contents: scheduler FSM state enum, arbiter grant enum, Avalon word addresses, MAX_NOTE.
package octave_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ARB       = 2'd1,
    ST_WAIT_TICK = 2'd2,
    ST_APPLY     = 2'd3
  } state_t;

  typedef enum logic {
    GRANT_HOST = 1'b0,
    GRANT_MIDI = 1'b1
  } grant_t;

  localparam logic [1:0] ADDR_STAGE   = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_APPLIED = 2'd2;
  localparam logic [1:0] ADDR_ENABLE  = 2'd3;

  // Highest note index inside one octave (C..B = 0..11).
  localparam int MAX_NOTE = 11;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-requester round-robin arbiter with last-grant register
// Ports:
//   clk, reset_n     : clock, asynchronous active-low reset
//   i_req_host       : host request
//   i_req_midi       : MIDI request
//   i_latch          : commit the current grant as last-grant
//   o_grant          : combinational grant for the current requests
module rr_arbiter2
  import octave_sched_pkg::*;
(
  input  logic   clk,
  input  logic   reset_n,
  input  logic   i_req_host,
  input  logic   i_req_midi,
  input  logic   i_latch,
  output grant_t o_grant
);

  grant_t r_last;
  grant_t w_grant;

  // On a tie the side that did not win last time gets the grant.
  always_comb begin
    w_grant = GRANT_HOST;
    if (i_req_host && i_req_midi) begin
      w_grant = (r_last == GRANT_MIDI) ? GRANT_HOST : GRANT_MIDI;
    end else if (i_req_midi) begin
      w_grant = GRANT_MIDI;
    end
  end

  // Reset to MIDI so the host wins the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last <= GRANT_MIDI;
    end else if (i_latch) begin
      r_last <= w_grant;
    end
  end

  assign o_grant = w_grant;

endmodule

// File: rtl/octave_param_scheduler.sv
// rtl/octave_param_scheduler.sv - host/MIDI octave+note scheduler applied on audio sample ticks
// Optional feature: define OCTAVE_SCHED_OVERRUN_CNT_EN for the 8-bit overrun counter at addr 1 [15:8].
// Ports:
//   clk, reset_n                        : clock, asynchronous active-low reset
//   address, chipselect, write_n,
//   writedata, readdata                 : Avalon-MM slave (readdata is combinational)
//   midi_req, midi_octave, midi_note    : MIDI request (level) and its values
//   midi_ack                            : one-cycle pulse when the MIDI request is retired
//   sample_tick                         : audio sample strobe, the only update point
//   octave_out, note_out                : applied values to the synth datapath
//   update_strobe                       : pulse in the cycle after the outputs change
module octave_param_scheduler
  import octave_sched_pkg::*;
#(
  parameter int OCT_W      = 3,
  parameter int NOTE_W     = 4,
  parameter int MAX_OCTAVE = 7
)
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic              midi_req,
  input  logic [OCT_W-1:0]  midi_octave,
  input  logic [NOTE_W-1:0] midi_note,
  output logic              midi_ack,
  input  logic              sample_tick,
  output logic [OCT_W-1:0]  octave_out,
  output logic [NOTE_W-1:0] note_out,
  output logic              update_strobe
);

  // One extra bit so the compare never degenerates when MAX_OCTAVE fills the field.
  localparam logic [OCT_W:0]  MAX_OCT_V  = (OCT_W+1)'(MAX_OCTAVE);
  localparam logic [NOTE_W:0] MAX_NOTE_V = (NOTE_W+1)'(MAX_NOTE);

  state_t            r_state;
  state_t            w_state_nxt;
  grant_t            r_grant;
  grant_t            w_arb_grant;
  logic [OCT_W-1:0]  r_stg_oct;
  logic [NOTE_W-1:0] r_stg_note;
  logic              r_host_pend;
  logic              r_err;
  logic              r_enable;
  logic [OCT_W-1:0]  r_oct_out;
  logic [NOTE_W-1:0] r_note_out;
  logic              r_upd;

  logic              w_wr;
  logic              w_wr_stage;
  logic              w_wr_status;
  logic              w_wr_enable;
  logic              w_latch;
  logic              w_apply;
  logic              w_busy;
  logic [OCT_W-1:0]  w_src_oct;
  logic [NOTE_W-1:0] w_src_note;
  logic [OCT_W-1:0]  w_oct_clamped;
  logic              w_note_ok;
  logic              w_unused_wd;

  assign w_wr        = chipselect & ~write_n;
  assign w_wr_stage  = w_wr && (address == ADDR_STAGE);
  assign w_wr_status = w_wr && (address == ADDR_STATUS);
  assign w_wr_enable = w_wr && (address == ADDR_ENABLE);
  assign w_busy      = (r_state != ST_IDLE);
  assign w_unused_wd = ^writedata;

  rr_arbiter2 u_arb (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_req_host (r_host_pend),
    .i_req_midi (midi_req),
    .i_latch    (w_latch),
    .o_grant    (w_arb_grant)
  );

  // Next state and apply-phase controls.
  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_apply     = 1'b0;
    midi_ack    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // enable only gates new grants; a grant already taken runs to APPLY
        if (r_enable && (r_host_pend || midi_req)) w_state_nxt = ST_ARB;
      end
      ST_ARB: begin
        w_latch     = 1'b1;
        w_state_nxt = ST_WAIT_TICK;
      end
      ST_WAIT_TICK: begin
        if (sample_tick) w_state_nxt = ST_APPLY;
      end
      default: begin
        w_apply     = 1'b1;
        midi_ack    = (r_grant == GRANT_MIDI);
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // The granted source is sampled live in APPLY, so late host rewrites apply.
  assign w_src_oct     = (r_grant == GRANT_MIDI) ? midi_octave : r_stg_oct;
  assign w_src_note    = (r_grant == GRANT_MIDI) ? midi_note   : r_stg_note;
  assign w_oct_clamped = ({1'b0, w_src_oct} > MAX_OCT_V) ? MAX_OCT_V[OCT_W-1:0] : w_src_oct;
  assign w_note_ok     = ({1'b0, w_src_note} <= MAX_NOTE_V);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_grant     <= GRANT_HOST;
      r_stg_oct   <= '0;
      r_stg_note  <= '0;
      r_host_pend <= 1'b0;
      r_err       <= 1'b0;
      r_enable    <= 1'b1;
      r_oct_out   <= '0;
      r_note_out  <= '0;
      r_upd       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_upd   <= w_apply && w_note_ok;

      if (w_latch) r_grant <= w_arb_grant;

      if (w_wr_stage) begin
        r_stg_oct  <= writedata[OCT_W-1:0];
        r_stg_note <= writedata[4 +: NOTE_W];
      end

      // A staging write in the APPLY cycle re-arms the request.
      if (w_wr_stage) begin
        r_host_pend <= 1'b1;
      end else if (w_apply && (r_grant == GRANT_HOST)) begin
        r_host_pend <= 1'b0;
      end

      // A bad note in the same cycle as a clear still leaves err set.
      if (w_apply && !w_note_ok) begin
        r_err <= 1'b1;
      end else if (w_wr_status) begin
        r_err <= 1'b0;
      end

      if (w_wr_enable) r_enable <= writedata[0];

      if (w_apply && w_note_ok) begin
        r_oct_out  <= w_oct_clamped;
        r_note_out <= w_src_note;
      end
    end
  end

`ifdef OCTAVE_SCHED_OVERRUN_CNT_EN
  logic [7:0] r_ovr_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ovr_cnt <= 8'd0;
    end else if (w_wr_status) begin
      r_ovr_cnt <= 8'd0;
    end else if (w_wr_stage && r_host_pend && (r_ovr_cnt != 8'hFF)) begin
      r_ovr_cnt <= r_ovr_cnt + 8'd1;
    end
  end
`endif

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_STAGE: begin
        readdata[OCT_W-1:0]    = r_stg_oct;
        readdata[4 +: NOTE_W]  = r_stg_note;
      end
      ADDR_STATUS: begin
        readdata[3:0] = {r_err, midi_req, r_host_pend, w_busy};
`ifdef OCTAVE_SCHED_OVERRUN_CNT_EN
        readdata[15:8] = r_ovr_cnt;
`endif
      end
      ADDR_APPLIED: begin
        readdata[OCT_W-1:0]    = r_oct_out;
        readdata[4 +: NOTE_W]  = r_note_out;
      end
      default: begin
        readdata[0] = r_enable;
      end
    endcase
  end

  assign octave_out    = r_oct_out;
  assign note_out      = r_note_out;
  assign update_strobe = r_upd;

endmodule
